orient_bin_accum: RTL
=====================

# orient_bin_accum

Parametrised orientation-binning accumulator for the SIFT descriptor/orientation stage. It quantises a stream of gradient angle codes into bins relative to a latched reference orientation (modulo wrap), and accumulates gradient magnitude per relative bin over a window of NSAMP samples. When the window completes, it streams the histogram out one bin per handshake. It replaces fixed-size angle-to-bin lookup tables and adds accumulation, saturation and flow control.

## Interface
- ANG_W, 8, angle code width; codes 0..2^ANG_W-1 span one full turn
- BIN_SHIFT, 4, log2 of codes per bin; NBINS = 2^(ANG_W-BIN_SHIFT), BW = ANG_W-BIN_SHIFT
- MAG_W, 12, magnitude width (unsigned)
- ACC_W, 16, accumulator width per bin (unsigned, ACC_W >= MAG_W)
- NSAMP, 16, samples per window (>= 1)
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  window start pulse; honoured only in IDLE
- ref_ang  in  ANG_W  reference orientation; sampled when start is honoured
- in_valid  in  1  sample valid
- in_ready  out  1  sample accept; high only in ACCUM
- in_ang  in  ANG_W  sample angle code
- in_mag  in  MAG_W  sample magnitude
- out_valid  out  1  histogram bin valid; high only in DUMP
- out_ready  in  1  downstream accept
- out_bin  out  BW  relative bin index being presented
- out_acc  out  ACC_W  accumulated magnitude of out_bin
- out_last  out  1  high with out_valid when out_bin = NBINS-1
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ACCUM, DUMP.
- Reset: state IDLE; all accumulators, sample counter, dump index and ref_bin cleared; in_ready=0, out_valid=0, out_last=0, out_bin=0, out_acc=0, busy=0.
- IDLE: start=1 latches ref_bin = ref_ang >> BIN_SHIFT, clears all NBINS accumulators and the sample counter, then goes to ACCUM. in_valid is ignored.
- ACCUM: in_ready=1. On in_valid&&in_ready, compute rel = ((in_ang >> BIN_SHIFT) - ref_bin) mod NBINS as a BW-bit wrapping subtract. Then acc[rel] = min(acc[rel] + in_mag, 2^ACC_W-1), saturating and never wrapping. The counter increments. The NSAMP-th accept moves to DUMP with dump index 0.
- DUMP: out_valid=1, out_bin=index, out_acc=acc[index], out_last=(index==NBINS-1). On out_valid&&out_ready the index increments. The handshake on index NBINS-1 returns to IDLE. Outputs are held stable while out_ready=0.
- start outside IDLE is ignored; ref_bin is unchanged.
- Accumulators keep their values after DUMP until the next honoured start.
- Reset mid-window or mid-dump aborts immediately; the partial histogram is discarded.

## Timing
- start high at edge t: from t+ on, state is ACCUM, in_ready=1, busy=1, all bins read 0.
- Accumulation latency is 1 edge: a sample accepted at edge e is reflected in acc at e+.
- The NSAMP-th accept at edge e puts the block in DUMP at e+. in_ready=0 and out_valid=1 (bin 0) in the same cycle. No extra sample is accepted.
- Dump takes a minimum of NBINS cycles with out_ready held high.
- The last dump handshake at edge d gives IDLE at d+: busy=0, out_valid=0. start may be honoured at the next edge.
- Minimum window period is 1 + NSAMP + NBINS cycles.
- in_ready and out_valid are never high together.

## Test plan
- Defaults, NSAMP=4, ref_ang=0x00, samples (ang,mag) = (0x00,1),(0x0F,2),(0x10,3),(0xFF,4) -> dump gives bin0=3, bin1=3, bin15=4, others 0; out_last only with bin 15.
- Wrap: NSAMP=3, ref_ang=0x85 (ref_bin 8), samples (0x70,5),(0x90,6),(0x8F,7) -> bin15=5, bin1=6, bin0=7.
- Saturation: NSAMP=20, ref_ang=0, 20 samples (0x20,4095) -> bin2=65535 (not 81900 mod 65536), others 0.
- Backpressure: during DUMP, toggle out_ready 0/1 every cycle -> out_bin/out_acc hold while out_ready=0; exactly 16 handshakes occur; busy falls the cycle after the bin-15 handshake.
- Reset mid-ACCUM after 2 accepted samples -> in_ready=0, busy=0 immediately. The next start plus NSAMP samples of (0x00,1) -> bin0=NSAMP, with no residue from the aborted window.
- Protocol: start pulses during ACCUM and DUMP with a different ref_ang -> ignored and binning unchanged; in_valid=1 in IDLE -> no accept, and no histogram change.

Source files
------------

// File: rtl/orient_bin_accum.sv
// ---------------------------------------------------------------------------
// orient_bin_accum
//
// Orientation-binning accumulator. Each sample's angle code is quantised to a
// bin (angle >> BIN_SHIFT), made relative to a reference bin latched at window
// start (BW-bit wrapping subtract, so the histogram rotates with the
// reference), and its magnitude is added with saturation into that relative
// bin. After NSAMP accepted samples the NBINS-entry histogram is streamed out
// one bin per valid/ready handshake.
//
// Ports
//   clk_i        clock, all state on rising edge
//   rst_i        asynchronous active-high reset; aborts any window in flight
//   start_i      window start pulse, honoured only in IDLE
//   ref_ang_i    reference orientation, sampled when start is honoured
//   in_valid_i   sample valid
//   in_ready_o   sample accept, high only while accumulating
//   in_ang_i     sample angle code
//   in_mag_i     sample magnitude (unsigned)
//   out_valid_o  histogram bin valid, high only while dumping
//   out_ready_i  downstream accept
//   out_bin_o    relative bin index being presented
//   out_acc_o    accumulated magnitude of out_bin_o
//   out_last_o   marks the final bin (NBINS-1) of the dump
//   busy_o       high whenever a window is accumulating or dumping
// ---------------------------------------------------------------------------
module orient_bin_accum #(
   parameter int ANG_W     = 8,
   parameter int BIN_SHIFT = 4,
   parameter int MAG_W     = 12,
   parameter int ACC_W     = 16,
   parameter int NSAMP     = 16
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         start_i,
   input  logic [ANG_W-1:0]             ref_ang_i,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic [ANG_W-1:0]             in_ang_i,
   input  logic [MAG_W-1:0]             in_mag_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [ANG_W-BIN_SHIFT-1:0]   out_bin_o,
   output logic [ACC_W-1:0]             out_acc_o,
   output logic                         out_last_o,
   output logic                         busy_o
);

   localparam int BW    = ANG_W - BIN_SHIFT;
   localparam int NBINS = 1 << BW;
   localparam int CNT_W = (NSAMP > 1) ? $clog2(NSAMP) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DUMP  = 2'd2
   } state_t;

   // Add a magnitude to an accumulator, clamping at all-ones instead of wrapping.
   function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                input logic [MAG_W-1:0] b);
      logic [ACC_W:0] sum;
      sum = {1'b0, a} + {{(ACC_W + 1 - MAG_W){1'b0}}, b};
      if (sum[ACC_W]) begin
         sat_add = {ACC_W{1'b1}};
      end else begin
         sat_add = sum[ACC_W-1:0];
      end
   endfunction

   state_t            state_q, state_d;
   logic [BW-1:0]     ref_bin_q, ref_bin_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [BW-1:0]     idx_q, idx_d;
   logic [ACC_W-1:0]  acc_q [NBINS];
   logic [ACC_W-1:0]  acc_d [NBINS];

   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic [BW-1:0]     out_bin_q, out_bin_d;
   logic [ACC_W-1:0]  out_acc_q, out_acc_d;
   logic              out_last_q, out_last_d;
   logic              busy_q, busy_d;

   logic [BW-1:0]     ang_bin_s;
   logic [BW-1:0]     rel_s;
   logic              accept_s;
   logic              unused_low_bits_s;

   // Only the bin part of each angle code matters; the sub-bin bits are dropped.
   assign ang_bin_s         = in_ang_i[ANG_W-1:BIN_SHIFT];
   assign rel_s             = ang_bin_s - ref_bin_q;   // wraps modulo NBINS
   assign accept_s          = in_valid_i & in_ready_q;
   assign unused_low_bits_s = ^{in_ang_i[BIN_SHIFT-1:0], ref_ang_i[BIN_SHIFT-1:0]};

   // Next-state, accumulator update and next-output computation.
   always_comb begin
      state_d   = state_q;
      ref_bin_d = ref_bin_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      acc_d     = acc_q;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               ref_bin_d = ref_ang_i[ANG_W-1:BIN_SHIFT];
               cnt_d     = {CNT_W{1'b0}};
               idx_d     = {BW{1'b0}};
               for (int i = 0; i < NBINS; i++) begin
                  acc_d[i] = {ACC_W{1'b0}};
               end
               state_d   = ST_ACCUM;
            end else begin
               state_d   = ST_IDLE;
            end
         end
         ST_ACCUM: begin
            if (accept_s) begin
               acc_d[rel_s] = sat_add(acc_q[rel_s], in_mag_i);
               if (cnt_q == CNT_W'(NSAMP - 1)) begin
                  cnt_d   = {CNT_W{1'b0}};
                  idx_d   = {BW{1'b0}};
                  state_d = ST_DUMP;
               end else begin
                  cnt_d   = cnt_q + CNT_W'(1);
               end
            end else begin
               state_d = ST_ACCUM;
            end
         end
         ST_DUMP: begin
            if (out_ready_i) begin
               if (idx_q == {BW{1'b1}}) begin
                  idx_d   = {BW{1'b0}};
                  state_d = ST_IDLE;
               end else begin
                  idx_d   = idx_q + BW'(1);
               end
            end else begin
               state_d = ST_DUMP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are derived from the next state so they are registered yet
      // line up with the state they describe (no cycle of skew).
      in_ready_d  = (state_d == ST_ACCUM);
      out_valid_d = (state_d == ST_DUMP);
      busy_d      = (state_d != ST_IDLE);
      if (state_d == ST_DUMP) begin
         out_bin_d  = idx_d;
         out_acc_d  = acc_d[idx_d];   // includes a sample landing on the entry edge
         out_last_d = (idx_d == {BW{1'b1}});
      end else begin
         out_bin_d  = {BW{1'b0}};
         out_acc_d  = {ACC_W{1'b0}};
         out_last_d = 1'b0;
      end
   end

   // State, accumulator and registered-output update.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         ref_bin_q   <= {BW{1'b0}};
         cnt_q       <= {CNT_W{1'b0}};
         idx_q       <= {BW{1'b0}};
         for (int i = 0; i < NBINS; i++) begin
            acc_q[i] <= {ACC_W{1'b0}};
         end
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_bin_q   <= {BW{1'b0}};
         out_acc_q   <= {ACC_W{1'b0}};
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ref_bin_q   <= ref_bin_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         for (int i = 0; i < NBINS; i++) begin
            acc_q[i] <= acc_d[i];
         end
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_bin_q   <= out_bin_d;
         out_acc_q   <= out_acc_d;
         out_last_q  <= out_last_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign out_bin_o   = out_bin_q;
   assign out_acc_o   = out_acc_q;
   assign out_last_o  = out_last_q;
   assign busy_o      = busy_q;

endmodule
